// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a one-entry result slot and MTC0 halt tracking.
// Optional grant/conflict/stall counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int CTLCODE_WIDTH = 8,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Req0_Valid,
    input  logic [CTLCODE_WIDTH-1:0] i_Req0_ALUCTL,
    input  logic [DATA_WIDTH-1:0]    i_Req0_Op1,
    input  logic [DATA_WIDTH-1:0]    i_Req0_Op2,
    input  logic [TAG_WIDTH-1:0]     i_Req0_Tag,
    output logic                     o_Req0_Ready,
    input  logic                     i_Req1_Valid,
    input  logic [CTLCODE_WIDTH-1:0] i_Req1_ALUCTL,
    input  logic [DATA_WIDTH-1:0]    i_Req1_Op1,
    input  logic [DATA_WIDTH-1:0]    i_Req1_Op2,
    input  logic [TAG_WIDTH-1:0]     i_Req1_Tag,
    output logic                     o_Req1_Ready,
    output logic                     o_ALU_Valid,
    output logic [CTLCODE_WIDTH-1:0] o_ALU_ALUCTL,
    output logic [DATA_WIDTH-1:0]    o_ALU_Op1,
    output logic [DATA_WIDTH-1:0]    o_ALU_Op2,
    input  logic [DATA_WIDTH-1:0]    i_ALU_Result,
    input  logic                     i_ALU_Branch_Valid,
    input  logic                     i_ALU_Branch_Outcome,
    input  logic [15:0]              i_ALU_Pass_Done_Value,
    input  logic [1:0]               i_ALU_Pass_Done_Change,
    output logic                     o_Out_Valid,
    input  logic                     i_Out_Ready,
    output logic [DATA_WIDTH-1:0]    o_Out_Result,
    output logic                     o_Out_Branch_Valid,
    output logic                     o_Out_Branch_Outcome,
    output logic                     o_Out_ReqID,
    output logic [TAG_WIDTH-1:0]     o_Out_Tag,
    output logic                     o_Halted,
    output logic [1:0]               o_Status,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]              o_Gnt0_Count,
    output logic [31:0]              o_Gnt1_Count,
    output logic [31:0]              o_Conflict_Count,
    output logic [31:0]              o_Stall_Count,
`endif
    output logic [15:0]              o_Status_Value
);

    // state     | meaning
    // RUN       | issuing normally
    // HALT_DONE | DONE reported, issue stopped until reset
    // HALT_FAIL | FAIL reported, issue stopped until reset
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_DONE = 2'd1,
        ST_HALT_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] CHG_FAIL = 2'd2;
    localparam logic [1:0] CHG_DONE = 2'd3;

    state_t state, state_nxt;
    logic   last_gnt;
    logic   can_issue;
    logic   gnt0, gnt1;
    logic   accept;
    logic   win_id;

    assign o_Halted  = (state != ST_RUN);
    assign can_issue = !o_Halted && (!o_Out_Valid || i_Out_Ready);

    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        o_ALU_ALUCTL = '0;
        o_ALU_Op1    = '0;
        o_ALU_Op2    = '0;
        if (i_Req0_Valid && (!i_Req1_Valid || last_gnt)) begin
            gnt0 = 1'b1;
        end else if (i_Req1_Valid) begin
            gnt1 = 1'b1;
        end
        o_Req0_Ready = can_issue && gnt0;
        o_Req1_Ready = can_issue && gnt1;
        o_ALU_Valid  = can_issue && (i_Req0_Valid || i_Req1_Valid);
        // Operands are only presented while the grant is live, zero otherwise.
        if (o_Req0_Ready) begin
            o_ALU_ALUCTL = i_Req0_ALUCTL;
            o_ALU_Op1    = i_Req0_Op1;
            o_ALU_Op2    = i_Req0_Op2;
        end else if (o_Req1_Ready) begin
            o_ALU_ALUCTL = i_Req1_ALUCTL;
            o_ALU_Op1    = i_Req1_Op1;
            o_ALU_Op2    = i_Req1_Op2;
        end
    end

    assign accept = o_ALU_Valid;
    assign win_id = gnt1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (accept && i_ALU_Pass_Done_Change == CHG_DONE) begin
                    state_nxt = ST_HALT_DONE;
                end else if (accept && i_ALU_Pass_Done_Change == CHG_FAIL) begin
                    state_nxt = ST_HALT_FAIL;
                end
            end
            ST_HALT_DONE: state_nxt = ST_HALT_DONE;
            ST_HALT_FAIL: state_nxt = ST_HALT_FAIL;
            default:      state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            last_gnt             <= 1'b1;
            o_Out_Valid          <= 1'b0;
            o_Out_Result         <= '0;
            o_Out_Branch_Valid   <= 1'b0;
            o_Out_Branch_Outcome <= 1'b0;
            o_Out_ReqID          <= 1'b0;
            o_Out_Tag            <= '0;
            o_Status             <= 2'd0;
            o_Status_Value       <= 16'd0;
        end else begin
            if (accept) begin
                last_gnt             <= win_id;
                o_Out_Valid          <= 1'b1;
                o_Out_Result         <= i_ALU_Result;
                o_Out_Branch_Valid   <= i_ALU_Branch_Valid;
                o_Out_Branch_Outcome <= i_ALU_Branch_Outcome;
                o_Out_ReqID          <= win_id;
                o_Out_Tag            <= win_id ? i_Req1_Tag : i_Req0_Tag;
            end else if (i_Out_Ready && o_Out_Valid) begin
                o_Out_Valid <= 1'b0;
            end
            // accept already implies RUN, so halt states freeze status.
            if (accept && i_ALU_Pass_Done_Change != 2'd0) begin
                o_Status       <= i_ALU_Pass_Done_Change;
                o_Status_Value <= i_ALU_Pass_Done_Value;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Gnt0_Count     <= 32'd0;
            o_Gnt1_Count     <= 32'd0;
            o_Conflict_Count <= 32'd0;
            o_Stall_Count    <= 32'd0;
        end else begin
            if (i_Req0_Valid && o_Req0_Ready) o_Gnt0_Count <= o_Gnt0_Count + 32'd1;
            if (i_Req1_Valid && o_Req1_Ready) o_Gnt1_Count <= o_Gnt1_Count + 32'd1;
            if (can_issue && i_Req0_Valid && i_Req1_Valid) begin
                o_Conflict_Count <= o_Conflict_Count + 32'd1;
            end
            if (!can_issue && (i_Req0_Valid || i_Req1_Valid)) begin
                o_Stall_Count <= o_Stall_Count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter; the bench ALU adds the operands and flags ALUCTL 0x10 as a branch.
// Counter checks are included when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Req0_Valid, i_Req1_Valid;
    logic [7:0]  i_Req0_ALUCTL, i_Req1_ALUCTL;
    logic [31:0] i_Req0_Op1, i_Req0_Op2, i_Req1_Op1, i_Req1_Op2;
    logic [3:0]  i_Req0_Tag, i_Req1_Tag;
    logic        o_Req0_Ready, o_Req1_Ready;
    logic        o_ALU_Valid;
    logic [7:0]  o_ALU_ALUCTL;
    logic [31:0] o_ALU_Op1, o_ALU_Op2;
    logic [31:0] i_ALU_Result;
    logic        i_ALU_Branch_Valid, i_ALU_Branch_Outcome;
    logic [15:0] i_ALU_Pass_Done_Value;
    logic [1:0]  i_ALU_Pass_Done_Change;
    logic        o_Out_Valid;
    logic        i_Out_Ready;
    logic [31:0] o_Out_Result;
    logic        o_Out_Branch_Valid, o_Out_Branch_Outcome;
    logic        o_Out_ReqID;
    logic [3:0]  o_Out_Tag;
    logic        o_Halted;
    logic [1:0]  o_Status;
    logic [15:0] o_Status_Value;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] o_Gnt0_Count, o_Gnt1_Count, o_Conflict_Count, o_Stall_Count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    assign i_ALU_Result         = o_ALU_Op1 + o_ALU_Op2;
    assign i_ALU_Branch_Valid   = (o_ALU_ALUCTL == 8'h10);
    assign i_ALU_Branch_Outcome = (o_ALU_ALUCTL == 8'h10) && (o_ALU_Op1 == o_ALU_Op2);

    alu_share_arbiter dut (
        .i_Clk                 (i_Clk),
        .i_Reset               (i_Reset),
        .i_Req0_Valid          (i_Req0_Valid),
        .i_Req0_ALUCTL         (i_Req0_ALUCTL),
        .i_Req0_Op1            (i_Req0_Op1),
        .i_Req0_Op2            (i_Req0_Op2),
        .i_Req0_Tag            (i_Req0_Tag),
        .o_Req0_Ready          (o_Req0_Ready),
        .i_Req1_Valid          (i_Req1_Valid),
        .i_Req1_ALUCTL         (i_Req1_ALUCTL),
        .i_Req1_Op1            (i_Req1_Op1),
        .i_Req1_Op2            (i_Req1_Op2),
        .i_Req1_Tag            (i_Req1_Tag),
        .o_Req1_Ready          (o_Req1_Ready),
        .o_ALU_Valid           (o_ALU_Valid),
        .o_ALU_ALUCTL          (o_ALU_ALUCTL),
        .o_ALU_Op1             (o_ALU_Op1),
        .o_ALU_Op2             (o_ALU_Op2),
        .i_ALU_Result          (i_ALU_Result),
        .i_ALU_Branch_Valid    (i_ALU_Branch_Valid),
        .i_ALU_Branch_Outcome  (i_ALU_Branch_Outcome),
        .i_ALU_Pass_Done_Value (i_ALU_Pass_Done_Value),
        .i_ALU_Pass_Done_Change(i_ALU_Pass_Done_Change),
        .o_Out_Valid           (o_Out_Valid),
        .i_Out_Ready           (i_Out_Ready),
        .o_Out_Result          (o_Out_Result),
        .o_Out_Branch_Valid    (o_Out_Branch_Valid),
        .o_Out_Branch_Outcome  (o_Out_Branch_Outcome),
        .o_Out_ReqID           (o_Out_ReqID),
        .o_Out_Tag             (o_Out_Tag),
        .o_Halted              (o_Halted),
        .o_Status              (o_Status),
`ifdef ALU_ARB_STATS_EN
        .o_Gnt0_Count          (o_Gnt0_Count),
        .o_Gnt1_Count          (o_Gnt1_Count),
        .o_Conflict_Count      (o_Conflict_Count),
        .o_Stall_Count         (o_Stall_Count),
`endif
        .o_Status_Value        (o_Status_Value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        i_Reset = 1'b1;
        i_Req0_Valid = 1'b0; i_Req0_ALUCTL = '0; i_Req0_Op1 = '0; i_Req0_Op2 = '0; i_Req0_Tag = '0;
        i_Req1_Valid = 1'b0; i_Req1_ALUCTL = '0; i_Req1_Op1 = '0; i_Req1_Op2 = '0; i_Req1_Tag = '0;
        i_ALU_Pass_Done_Value = '0; i_ALU_Pass_Done_Change = '0;
        i_Out_Ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(o_Out_Valid), 32'd0);
        chk("rst_result", o_Out_Result, 32'd0);
        chk("rst_status", 32'(o_Status), 32'd0);
        chk("rst_halted", 32'(o_Halted), 32'd0);
        i_Reset = 1'b0;

        // Req0 alone: 5 + 7
        i_Req0_Valid = 1'b1; i_Req0_ALUCTL = 8'd1; i_Req0_Op1 = 32'd5; i_Req0_Op2 = 32'd7; i_Req0_Tag = 4'd3;
        #1;
        chk("solo_ready0", 32'(o_Req0_Ready), 32'd1);
        chk("solo_ready1", 32'(o_Req1_Ready), 32'd0);
        chk("solo_alu_valid", 32'(o_ALU_Valid), 32'd1);
        chk("solo_alu_op1", o_ALU_Op1, 32'd5);
        tick();
        i_Req0_Valid = 1'b0;
        chk("solo_out_valid", 32'(o_Out_Valid), 32'd1);
        chk("solo_result", o_Out_Result, 32'd12);
        chk("solo_reqid", 32'(o_Out_ReqID), 32'd0);
        chk("solo_tag", 32'(o_Out_Tag), 32'd3);

        // Req1 alone: 2 + 3, leaves the pointer at Req1
        i_Req1_Valid = 1'b1; i_Req1_ALUCTL = 8'd1; i_Req1_Op1 = 32'd2; i_Req1_Op2 = 32'd3; i_Req1_Tag = 4'd5;
        #1;
        chk("solo1_ready1", 32'(o_Req1_Ready), 32'd1);
        tick();
        chk("solo1_result", o_Out_Result, 32'd5);
        chk("solo1_reqid", 32'(o_Out_ReqID), 32'd1);

        // Tie for 4 cycles: Req0, Req1, Req0, Req1
        i_Req0_Valid = 1'b1; i_Req0_Op1 = 32'd10; i_Req0_Op2 = 32'd20; i_Req0_Tag = 4'd1;
        i_Req1_Valid = 1'b1; i_Req1_Op1 = 32'd100; i_Req1_Op2 = 32'd1; i_Req1_Tag = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_ready0", 32'(o_Req0_Ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_ready1", 32'(o_Req1_Ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("tie_reqid", 32'(o_Out_ReqID), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("tie_tag", 32'(o_Out_Tag), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("tie_result", o_Out_Result, (i % 2 == 0) ? 32'd30 : 32'd101);
        end
        i_Req0_Valid = 1'b0; i_Req1_Valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(o_Out_Valid), 32'd0);

        // Fill slot with a branch op while downstream stalls
        i_Out_Ready = 1'b0;
        i_Req0_Valid = 1'b1; i_Req0_ALUCTL = 8'h10; i_Req0_Op1 = 32'd4; i_Req0_Op2 = 32'd4; i_Req0_Tag = 4'd6;
        tick();
        i_Req0_Valid = 1'b0;
        chk("full_result", o_Out_Result, 32'd8);
        chk("full_br_valid", 32'(o_Out_Branch_Valid), 32'd1);
        chk("full_br_outcome", 32'(o_Out_Branch_Outcome), 32'd1);
        i_Req1_Valid = 1'b1; i_Req1_ALUCTL = 8'd1; i_Req1_Op1 = 32'd9; i_Req1_Op2 = 32'd1; i_Req1_Tag = 4'd7;
        #1;
        chk("full_ready1", 32'(o_Req1_Ready), 32'd0);
        chk("full_ready0", 32'(o_Req0_Ready), 32'd0);
        chk("full_alu_valid", 32'(o_ALU_Valid), 32'd0);
        tick();
        chk("full_hold_valid", 32'(o_Out_Valid), 32'd1);
        chk("full_hold_result", o_Out_Result, 32'd8);
        i_Out_Ready = 1'b1;
        #1;
        chk("swap_ready1", 32'(o_Req1_Ready), 32'd1);
        tick();
        i_Req1_Valid = 1'b0;
        chk("swap_out_valid", 32'(o_Out_Valid), 32'd1);
        chk("swap_result", o_Out_Result, 32'd10);
        chk("swap_reqid", 32'(o_Out_ReqID), 32'd1);
        chk("swap_tag", 32'(o_Out_Tag), 32'd7);
        chk("swap_br_valid", 32'(o_Out_Branch_Valid), 32'd0);

        // PASS then DONE
        i_Req0_Valid = 1'b1; i_Req0_ALUCTL = 8'd1; i_Req0_Op1 = 32'd1; i_Req0_Op2 = 32'd1; i_Req0_Tag = 4'd8;
        i_ALU_Pass_Done_Change = 2'd1; i_ALU_Pass_Done_Value = 16'h0007;
        tick();
        chk("pass_status", 32'(o_Status), 32'd1);
        chk("pass_value", 32'(o_Status_Value), 32'h7);
        chk("pass_halted", 32'(o_Halted), 32'd0);
        i_ALU_Pass_Done_Change = 2'd3; i_ALU_Pass_Done_Value = 16'h00FF;
        #1;
        chk("done_ready0", 32'(o_Req0_Ready), 32'd1);
        tick();
        chk("done_status", 32'(o_Status), 32'd3);
        chk("done_value", 32'(o_Status_Value), 32'hFF);
        chk("done_halted", 32'(o_Halted), 32'd1);
        chk("done_out_valid", 32'(o_Out_Valid), 32'd1);
        i_ALU_Pass_Done_Change = 2'd2; i_ALU_Pass_Done_Value = 16'h0042;
        #1;
        chk("halt_ready0", 32'(o_Req0_Ready), 32'd0);
        chk("halt_alu_valid", 32'(o_ALU_Valid), 32'd0);
        tick();
        chk("halt_drained", 32'(o_Out_Valid), 32'd0);
        chk("halt_status_frozen", 32'(o_Status), 32'd3);
        chk("halt_value_frozen", 32'(o_Status_Value), 32'hFF);

        // FAIL from RUN with the slot held full
        i_Req0_Valid = 1'b0;
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        i_Out_Ready = 1'b0;
        i_Req0_Valid = 1'b1;
        tick();
        i_Req0_Valid = 1'b0; i_ALU_Pass_Done_Change = 2'd0;
        chk("fail_status", 32'(o_Status), 32'd2);
        chk("fail_value", 32'(o_Status_Value), 32'h42);
        chk("fail_halted", 32'(o_Halted), 32'd1);
        chk("fail_out_valid", 32'(o_Out_Valid), 32'd1);

        // Reset while halted and slot full, then a tie
        i_Req0_Valid = 1'b1; i_Req1_Valid = 1'b1; i_Req0_Tag = 4'd1; i_Req1_Tag = 4'd2;
        i_Reset = 1'b1;
        tick();
        chk("rst2_out_valid", 32'(o_Out_Valid), 32'd0);
        chk("rst2_status", 32'(o_Status), 32'd0);
        chk("rst2_value", 32'(o_Status_Value), 32'd0);
        chk("rst2_halted", 32'(o_Halted), 32'd0);
        chk("rst2_result", o_Out_Result, 32'd0);
        chk("rst2_tag", 32'(o_Out_Tag), 32'd0);
        i_Reset = 1'b0;
        i_Out_Ready = 1'b1;
        #1;
        chk("rst2_tie_ready0", 32'(o_Req0_Ready), 32'd1);
        chk("rst2_tie_ready1", 32'(o_Req1_Ready), 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("stat_conflict_zero", o_Conflict_Count, 32'd0);
`endif
        tick(); tick(); tick();
        chk("rst2_last_reqid", 32'(o_Out_ReqID), 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("stat_conflict", o_Conflict_Count, 32'd3);
        chk("stat_gnt0", o_Gnt0_Count, 32'd2);
        chk("stat_gnt1", o_Gnt1_Count, 32'd1);
        chk("stat_stall", o_Stall_Count, 32'd0);
`endif
        i_Req0_Valid = 1'b0; i_Req1_Valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
